// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI slave engine oversampling ss/sclk/mosi in the PCLK domain,
// shifting 8-bit frames in all CPOL/CPHA modes with a one-byte TX buffer and RX holding register.
module spi_slave_responder #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] IDLE_TX_BYTE = 8'hFF
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic       lsbfe_i,
    input  logic       ss_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ack_i,
    output logic       busy_o,
    output logic       rx_overrun_o,
    output logic       tx_underrun_o,
    output logic       frame_err_o,
    input  logic       clr_err_i
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_ss_d;
    logic                   r_sclk_d;
    logic                   r_cpol;
    logic                   r_cpha;
    logic                   r_lsbfe;
    logic [3:0]             r_cnt;
    logic [7:0]             r_tx_sr;
    logic [7:0]             r_rx_sr;
    logic [7:0]             r_tx_buf;
    logic                   r_tx_full;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_miso;
    logic                   r_miso_oe;
    logic                   r_busy;
    logic                   r_rx_overrun;
    logic                   r_tx_underrun;
    logic                   r_frame_err;

    logic       w_ss;
    logic       w_sclk;
    logic       w_mosi;
    logic       w_ss_fall;
    logic       w_ss_rise;
    logic       w_lead;
    logic       w_trail;
    logic       w_sample;
    logic       w_shift;
    logic       w_tx_load;
    logic [7:0] w_load_byte;
    logic [7:0] w_tx_next;
    logic [7:0] w_rx_next;
    logic       w_head_load;
    logic       w_head_next;
    logic       w_head_cur;

    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_fall   = r_ss_d & ~w_ss;
    assign w_ss_rise   = ~r_ss_d & w_ss;
    assign w_lead      = (r_sclk_d == r_cpol) && (w_sclk != r_cpol);
    assign w_trail     = (r_sclk_d != r_cpol) && (w_sclk == r_cpol);
    assign w_sample    = (r_state == S_SHIFT) && (r_cpha ? w_trail : w_lead);
    assign w_shift     = (r_state == S_SHIFT) && (r_cpha ? w_lead : w_trail);
    assign w_tx_load   = tx_valid_i && !r_tx_full;
    assign w_load_byte = r_tx_full ? r_tx_buf : IDLE_TX_BYTE;
    assign w_tx_next   = r_lsbfe ? {1'b0, r_tx_sr[7:1]} : {r_tx_sr[6:0], 1'b0};
    assign w_rx_next   = r_lsbfe ? {w_mosi, r_rx_sr[7:1]} : {r_rx_sr[6:0], w_mosi};
    assign w_head_load = r_lsbfe ? w_load_byte[0] : w_load_byte[7];
    assign w_head_next = r_lsbfe ? w_tx_next[0] : w_tx_next[7];
    assign w_head_cur  = r_lsbfe ? r_tx_sr[0] : r_tx_sr[7];

    assign miso_o        = r_miso;
    assign miso_oe_o     = r_miso_oe;
    assign tx_ready_o    = ~r_tx_full;
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign busy_o        = r_busy;
    assign rx_overrun_o  = r_rx_overrun;
    assign tx_underrun_o = r_tx_underrun;
    assign frame_err_o   = r_frame_err;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= S_IDLE;
            r_ss_sync     <= {SYNC_STAGES{1'b1}};
            r_sclk_sync   <= {SYNC_STAGES{cpol_i}};
            r_mosi_sync   <= '0;
            r_ss_d        <= 1'b1;
            r_sclk_d      <= cpol_i;
            r_cpol        <= cpol_i;
            r_cpha        <= cpha_i;
            r_lsbfe       <= lsbfe_i;
            r_cnt         <= '0;
            r_tx_sr       <= '0;
            r_rx_sr       <= '0;
            r_tx_buf      <= '0;
            r_tx_full     <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_busy        <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_i};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_ss_d      <= w_ss;
            r_sclk_d    <= w_sclk;
            r_frame_err <= 1'b0;
            if (w_tx_load) begin
                r_tx_buf  <= tx_data_i;
                r_tx_full <= 1'b1;
            end
            if (rx_ack_i)
                r_rx_valid <= 1'b0;
            if (clr_err_i) begin
                r_rx_overrun  <= 1'b0;
                r_tx_underrun <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_cpol  <= cpol_i;
                    r_cpha  <= cpha_i;
                    r_lsbfe <= lsbfe_i;
                    if (w_ss_fall) begin
                        r_state   <= S_LOAD;
                        r_busy    <= 1'b1;
                        r_miso_oe <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_tx_sr <= w_load_byte;
                    if (r_tx_full)
                        r_tx_full <= 1'b0;
                    else
                        r_tx_underrun <= 1'b1;
                    if (!r_cpha)
                        r_miso <= w_head_load;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_sample) begin
                        r_rx_sr <= w_rx_next;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7)
                            r_state <= S_DONE;
                    end
                    // At count 0 a CPHA=1 leading edge presents bit 0; a CPHA=0 trailing edge is the previous frame's last
                    if (w_shift) begin
                        if (r_cnt != 4'd0) begin
                            r_tx_sr <= w_tx_next;
                            r_miso  <= w_head_next;
                        end else if (r_cpha) begin
                            r_miso <= w_head_cur;
                        end
                    end
                end
                S_DONE: begin
                    r_rx_data  <= r_rx_sr;
                    r_rx_valid <= 1'b1;
                    if (r_rx_valid && !rx_ack_i)
                        r_rx_overrun <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= w_ss ? S_IDLE : S_LOAD;
                    if (w_ss) begin
                        r_busy    <= 1'b0;
                        r_miso_oe <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_ss_rise) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_miso_oe <= 1'b0;
                r_miso    <= 1'b0;
                r_cnt     <= '0;
                if (r_state == S_SHIFT && r_cnt != 4'd0)
                    r_frame_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: bus-functional SPI master driving the responder; received bytes are
// scoreboarded against a queue of expected bytes pushed when each frame is driven.
module tb_spi_slave_responder;
    localparam int HALF = 8;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       cpol_i = 1'b0;
    logic       cpha_i = 1'b0;
    logic       lsbfe_i = 1'b0;
    logic       ss_i = 1'b1;
    logic       sclk_i = 1'b0;
    logic       mosi_i = 1'b0;
    logic       miso_o;
    logic       miso_oe_o;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ack_i = 1'b0;
    logic       busy_o;
    logic       rx_overrun_o;
    logic       tx_underrun_o;
    logic       frame_err_o;
    logic       clr_err_i = 1'b0;

    int         n_chk = 0;
    int         n_err = 0;
    int         fe_cnt = 0;
    int         fe0;
    logic [7:0] exp_q[$];
    logic       prev_v = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       mid_busy, mid_oe, mid_rdy;
    logic [7:0] got, got2;

    always #5 PCLK = ~PCLK;

    spi_slave_responder #(.SYNC_STAGES(2), .IDLE_TX_BYTE(8'hFF)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .cpol_i(cpol_i), .cpha_i(cpha_i), .lsbfe_i(lsbfe_i),
        .ss_i(ss_i), .sclk_i(sclk_i), .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe_o(miso_oe_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ack_i(rx_ack_i), .busy_o(busy_o),
        .rx_overrun_o(rx_overrun_o), .tx_underrun_o(tx_underrun_o), .frame_err_o(frame_err_o),
        .clr_err_i(clr_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    // A new valid byte, or a changed byte while still valid, is one DUT result
    always @(negedge PCLK) begin
        if (!PRESET && rx_valid_o && (!prev_v || rx_data_o != prev_d)) begin
            chk("rx_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                chk("rx_data", 32'(rx_data_o), 32'(exp_q.pop_front()));
        end
        if (frame_err_o)
            fe_cnt++;
        prev_v = rx_valid_o;
        prev_d = rx_data_o;
    end

    task automatic tx_load(input logic [7:0] d);
        @(negedge PCLK);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(negedge PCLK);
        tx_valid_i = 1'b0;
    endtask

    task automatic rx_ack();
        @(negedge PCLK);
        rx_ack_i = 1'b1;
        @(negedge PCLK);
        rx_ack_i = 1'b0;
        chk("ack_clears", 32'(rx_valid_o), 32'd0);
    endtask

    task automatic clr_err();
        @(negedge PCLK);
        clr_err_i = 1'b1;
        @(negedge PCLK);
        clr_err_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++)
            @(negedge PCLK);
        chk("rx_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic xfer(input logic [7:0] mo, input logic pol, input logic pha, input logic lsb,
                        input int nbits, input bit keep, output logic [7:0] mi);
        logic [7:0] m;
        m = 8'h00;
        if (ss_i) begin
            cpol_i  = pol;
            cpha_i  = pha;
            lsbfe_i = lsb;
            sclk_i  = pol;
            wait_cyc(8);
            ss_i = 1'b0;
            wait_cyc(8);
        end
        for (int i = 0; i < nbits; i++) begin
            automatic int b = lsb ? i : 7 - i;
            if (!pha) begin
                mosi_i = mo[b];
                wait_cyc(HALF);
                m[b] = miso_o;
                if (i == 0) begin
                    mid_busy = busy_o; mid_oe = miso_oe_o; mid_rdy = tx_ready_o;
                end
                sclk_i = ~pol;
                wait_cyc(HALF);
                sclk_i = pol;
            end else begin
                wait_cyc(HALF);
                if (i == 0) begin
                    mid_busy = busy_o; mid_oe = miso_oe_o; mid_rdy = tx_ready_o;
                end
                sclk_i = ~pol;
                mosi_i = mo[b];
                wait_cyc(HALF);
                sclk_i = pol;
                m[b] = miso_o;
            end
        end
        wait_cyc(HALF);
        if (!keep) begin
            ss_i = 1'b1;
            wait_cyc(8);
        end
        mi = m;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        wait_cyc(3);
        chk("rst_miso", 32'(miso_o), 32'd0);
        chk("rst_oe", 32'(miso_oe_o), 32'd0);
        chk("rst_rdy", 32'(tx_ready_o), 32'd1);
        chk("rst_rxd", 32'(rx_data_o), 32'h00);
        chk("rst_rxv", 32'(rx_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_errs", {29'd0, rx_overrun_o, tx_underrun_o, frame_err_o}, 32'd0);
        PRESET = 1'b0;
        wait_cyc(4);

        // Mode 0, MSB first
        tx_load(8'hA5);
        chk("m0_rdy_full", 32'(tx_ready_o), 32'd0);
        exp_q.push_back(8'h3C);
        xfer(8'h3C, 1'b0, 1'b0, 1'b0, 8, 1'b0, got);
        chk("m0_miso", 32'(got), 32'hA5);
        chk("m0_mid_busy", 32'(mid_busy), 32'd1);
        chk("m0_mid_oe", 32'(mid_oe), 32'd1);
        chk("m0_mid_rdy", 32'(mid_rdy), 32'd1);
        drain();
        chk("m0_rxv_hold", 32'(rx_valid_o), 32'd1);
        chk("m0_busy_end", 32'(busy_o), 32'd0);
        chk("m0_oe_end", 32'(miso_oe_o), 32'd0);
        chk("m0_ovr", 32'(rx_overrun_o), 32'd0);
        rx_ack();

        // Modes 1..3, LSB first
        for (int md = 1; md < 4; md++) begin
            tx_load(8'h81);
            exp_q.push_back(8'h7E);
            xfer(8'h7E, md[1], md[0], 1'b1, 8, 1'b0, got);
            chk($sformatf("m%0d_miso", md), 32'(got), 32'h81);
            drain();
            rx_ack();
        end

        // Back-to-back frames, second TX byte loaded mid-frame, no ack in between
        tx_load(8'h11);
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h69);
        fork
            xfer(8'h96, 1'b0, 1'b0, 1'b0, 8, 1'b1, got);
            begin
                wait_cyc(40);
                tx_load(8'h5A);
            end
        join
        xfer(8'h69, 1'b0, 1'b0, 1'b0, 8, 1'b0, got2);
        chk("b2b_miso1", 32'(got), 32'h11);
        chk("b2b_miso2", 32'(got2), 32'h5A);
        drain();
        chk("b2b_ovr", 32'(rx_overrun_o), 32'd1);
        chk("b2b_rxd", 32'(rx_data_o), 32'h69);
        rx_ack();
        clr_err();
        chk("b2b_ovr_clr", 32'(rx_overrun_o), 32'd0);

        // Underrun: empty TX buffer at frame start
        chk("ur_pre", 32'(tx_underrun_o), 32'd0);
        chk("ur_rdy", 32'(tx_ready_o), 32'd1);
        exp_q.push_back(8'h42);
        xfer(8'h42, 1'b0, 1'b0, 1'b0, 8, 1'b0, got);
        chk("ur_miso", 32'(got), 32'hFF);
        chk("ur_flag", 32'(tx_underrun_o), 32'd1);
        drain();
        clr_err();
        chk("ur_clr", 32'(tx_underrun_o), 32'd0);

        // Frame error after 5 samples with an unread byte pending
        fe0 = fe_cnt;
        xfer(8'hB7, 1'b0, 1'b0, 1'b0, 5, 1'b0, got);
        chk("fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("fe_busy", 32'(busy_o), 32'd0);
        chk("fe_rxv", 32'(rx_valid_o), 32'd1);
        chk("fe_rxd", 32'(rx_data_o), 32'h42);
        rx_ack();
        tx_load(8'h3C);
        exp_q.push_back(8'hD2);
        xfer(8'hD2, 1'b0, 1'b0, 1'b0, 8, 1'b0, got);
        chk("fe_next_miso", 32'(got), 32'h3C);
        drain();
        rx_ack();

        // Reset mid-frame after 3 bits
        tx_load(8'h77);
        xfer(8'h55, 1'b0, 1'b0, 1'b0, 3, 1'b1, got);
        tx_load(8'hEE);
        chk("pr_rdy_full", 32'(tx_ready_o), 32'd0);
        chk("pr_busy_pre", 32'(busy_o), 32'd1);
        fe0 = fe_cnt;
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("pr_miso", 32'(miso_o), 32'd0);
        chk("pr_oe", 32'(miso_oe_o), 32'd0);
        chk("pr_rdy", 32'(tx_ready_o), 32'd1);
        chk("pr_rxd", 32'(rx_data_o), 32'h00);
        chk("pr_rxv", 32'(rx_valid_o), 32'd0);
        chk("pr_busy", 32'(busy_o), 32'd0);
        chk("pr_errs", {29'd0, rx_overrun_o, tx_underrun_o, frame_err_o}, 32'd0);
        ss_i   = 1'b1;
        sclk_i = 1'b0;
        wait_cyc(4);
        PRESET = 1'b0;
        wait_cyc(8);
        chk("pr_no_fe", 32'(fe_cnt - fe0), 32'd0);
        tx_load(8'h3C);
        exp_q.push_back(8'hC3);
        xfer(8'hC3, 1'b0, 1'b0, 1'b0, 8, 1'b0, got);
        chk("pr_next_miso", 32'(got), 32'h3C);
        drain();

        chk("fe_total", 32'(fe_cnt), 32'd1);
        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
